// File: rtl/tx_framer.sv
// tx_framer: buffers tagged words in a small FIFO and serialises them
// as start + LSB-first data + even parity + stop frames paced by txc.
module tx_framer #(
  parameter int DATA_W     = 8,
  parameter int ADRS_W     = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ADRS_W-1:0]             ramadrs,
  input  logic                          oeenable,
  input  logic                          txc,
  input  logic [DATA_W-1:0]             datain,
  input  logic                          clr_ovf,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [ADRS_W-1:0]             cur_adrs
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = ADRS_W + DATA_W;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t            state;
  logic              txc_q;
  logic              tick;
  logic [EW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [EW-1:0]     rd_word;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] sh;
  logic              par;
  logic [CW-1:0]     bitcnt;

  assign tick    = txc & ~txc_q;
  assign full    = (fifo_level == FULL);
  assign empty   = (fifo_level == '0);
  assign pop     = tick & ~empty & ((state == IDLE) | (state == STOP));
  assign push    = oeenable & (~full | pop);
  assign drop    = oeenable & full & ~pop;
  assign rd_word = mem[rd_ptr];

  // txc edge detector; reset high so a txc already high gives no tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) txc_q <= 1'b1;
    else       txc_q <= txc;
  end

  // FIFO storage; contents are dead once pointers reset
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {ramadrs, datain};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  // frame FSM with registered line, busy and tag outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      cur_adrs <= '0;
      sh       <= '0;
      par      <= 1'b0;
      bitcnt   <= '0;
    end else if (tick) begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            {cur_adrs, sh} <= rd_word;
            par   <= ^rd_word[DATA_W-1:0];
            txd   <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end else begin
            txd <= 1'b1;
          end
        end
        START: begin
          txd    <= sh[0];
          sh     <= sh >> 1;
          bitcnt <= '0;
          state  <= DATA;
        end
        DATA: begin
          if (bitcnt != LAST) begin
            txd    <= sh[0];
            sh     <= sh >> 1;
            bitcnt <= bitcnt + 1'b1;
          end else begin
            txd   <= par;
            state <= PARITY;
          end
        end
        PARITY: begin
          txd   <= 1'b1;
          state <= STOP;
        end
        STOP: begin
          if (!empty) begin
            {cur_adrs, sh} <= rd_word;
            par   <= ^rd_word[DATA_W-1:0];
            txd   <= 1'b0;
            state <= START;
          end else begin
            txd   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          txd   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: randomized and directed checks of tx_framer
// against a queue-based frame model.
module tb_tx_framer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] ramadrs = '0;
  logic       oeenable = 1'b0;
  logic       txc = 1'b0;
  logic [7:0] datain = '0;
  logic       clr_ovf = 1'b0;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [8:0] cur_adrs;

  int checks = 0;
  int errors = 0;

  // model: words waiting, bits left in current frame, visible outputs
  logic [16:0] mq[$];
  bit          line[$];
  bit          m_txd;
  bit          m_busy;
  bit          m_ovf;
  logic [8:0]  m_cur;

  tx_framer #(.DATA_W(8), .ADRS_W(9), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .ramadrs(ramadrs),
    .oeenable(oeenable), .txc(txc), .datain(datain),
    .clr_ovf(clr_ovf), .txd(txd), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow),
    .cur_adrs(cur_adrs)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_clear();
    mq.delete();
    line.delete();
    m_txd  = 1'b1;
    m_busy = 1'b0;
    m_ovf  = 1'b0;
    m_cur  = '0;
  endfunction

  // a tick emits the next frame bit; a finished frame starts the next word
  function automatic void model_tick();
    logic [16:0] w;
    if (line.size() == 0) begin
      if (mq.size() > 0) begin
        w = mq.pop_front();
        m_cur = w[16:8];
        line.push_back(1'b0);
        for (int b = 0; b < 8; b++) line.push_back(w[b]);
        line.push_back(^w[7:0]);
        line.push_back(1'b1);
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
        m_txd  = 1'b1;
      end
    end
    if (line.size() > 0) m_txd = line.pop_front();
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic push_word(input logic [8:0] a, input logic [7:0] d);
    ramadrs  = a;
    datain   = d;
    oeenable = 1'b1;
    step();
    oeenable = 1'b0;
    if (mq.size() < 4) mq.push_back({a, d});
    else               m_ovf = 1'b1;
  endtask

  task automatic tick();
    txc = 1'b1;
    step();
    model_tick();
    txc = 1'b0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 5;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL reset_txd got %b want 1", txd);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level got %0d want 0", fifo_level);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset_ovf got %b want 0", overflow);
    end
    if (cur_adrs !== 9'd0) begin
      errors++; $display("FAIL reset_adrs got %0h want 0", cur_adrs);
    end
  endtask

  task automatic test_known_frame();
    int exp_bits[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    push_word(9'h020, 8'hA5);
    for (int i = 0; i < 11; i++) begin
      tick();
      checks += 2;
      if (txd !== exp_bits[i][0]) begin
        errors++;
        $display("FAIL a5_bit%0d got %b want %0d", i, txd, exp_bits[i]);
      end
      if (busy !== 1'b1) begin
        errors++; $display("FAIL a5_busy%0d got %b want 1", i, busy);
      end
    end
    checks++;
    if (cur_adrs !== 9'h020) begin
      errors++; $display("FAIL a5_adrs got %0h want 020", cur_adrs);
    end
    tick();
    checks += 2;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL a5_busy_end got %b want 0", busy);
    end
    if (txd !== 1'b1) begin
      errors++; $display("FAIL a5_idle got %b want 1", txd);
    end
  endtask

  task automatic test_overflow();
    int n;
    for (int i = 0; i < 5; i++)
      push_word(9'($urandom), 8'($urandom));
    checks += 2;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL ovf_level got %0d want 4", fifo_level);
    end
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %b want 1", overflow);
    end
    clr_ovf = 1'b1;
    push_word(9'($urandom), 8'($urandom));
    clr_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_clr_drop got %b want 1", overflow);
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clr got %b want 0", overflow);
    end
    n = mq.size() * 11 + 1;
    for (int i = 0; i < n; i++) begin
      tick();
      checks += 3;
      if (txd !== m_txd) begin
        errors++; $display("FAIL ovf_txd%0d got %b want %b", i, txd, m_txd);
      end
      if (busy !== m_busy) begin
        errors++; $display("FAIL ovf_busy%0d got %b want %b", i, busy, m_busy);
      end
      if (cur_adrs !== m_cur) begin
        errors++; $display("FAIL ovf_adrs%0d got %0h want %0h", i, cur_adrs, m_cur);
      end
    end
  endtask

  task automatic test_push_pop_full();
    logic [8:0] a;
    logic [7:0] d;
    for (int i = 0; i < 4; i++)
      push_word(9'($urandom), 8'($urandom));
    a = 9'($urandom);
    d = 8'($urandom);
    ramadrs  = a;
    datain   = d;
    oeenable = 1'b1;
    txc      = 1'b1;
    step();
    oeenable = 1'b0;
    txc      = 1'b0;
    model_tick();
    mq.push_back({a, d});
    checks += 4;
    if (fifo_level !== 3'd4) begin
      errors++; $display("FAIL pp_level got %0d want 4", fifo_level);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL pp_ovf got %b want 0", overflow);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL pp_busy got %b want 1", busy);
    end
    if (txd !== 1'b0) begin
      errors++; $display("FAIL pp_start got %b want 0", txd);
    end
    step();
    for (int i = 0; i < 55; i++) begin
      tick();
      checks += 2;
      if (txd !== m_txd) begin
        errors++; $display("FAIL pp_txd%0d got %b want %b", i, txd, m_txd);
      end
      if (cur_adrs !== m_cur) begin
        errors++; $display("FAIL pp_adrs%0d got %0h want %0h", i, cur_adrs, m_cur);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL pp_end_busy got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    push_word(9'($urandom), 8'($urandom));
    push_word(9'($urandom), 8'($urandom));
    for (int i = 0; i < 23; i++) begin
      tick();
      checks += 2;
      if (txd !== m_txd) begin
        errors++; $display("FAIL b2b_txd%0d got %b want %b", i, txd, m_txd);
      end
      if (busy !== m_busy) begin
        errors++; $display("FAIL b2b_busy%0d got %b want %b", i, busy, m_busy);
      end
      if (i == 11) begin
        checks += 2;
        if (txd !== 1'b0) begin
          errors++; $display("FAIL b2b_gap got %b want 0", txd);
        end
        if (busy !== 1'b1) begin
          errors++; $display("FAIL b2b_hold got %b want 1", busy);
        end
      end
    end
  endtask

  task automatic test_txc_reset();
    txc = 1'b1;
    apply_reset();
    push_word(9'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      step();
      checks += 2;
      if (txd !== 1'b1) begin
        errors++; $display("FAIL txch_txd%0d got %b want 1", i, txd);
      end
      if (busy !== 1'b0) begin
        errors++; $display("FAIL txch_busy%0d got %b want 0", i, busy);
      end
    end
    txc = 1'b0;
    step();
    txc = 1'b1;
    step();
    model_tick();
    txc = 1'b0;
    checks += 2;
    if (txd !== 1'b0) begin
      errors++; $display("FAIL txch_start got %b want 0", txd);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL txch_busy got %b want 1", busy);
    end
    step();
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (txd !== m_txd) begin
        errors++; $display("FAIL txch_txd%0d got %b want %b", i, txd, m_txd);
      end
    end
  endtask

  task automatic test_reset_mid();
    push_word(9'($urandom), 8'($urandom));
    push_word(9'($urandom), 8'($urandom));
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (txd !== m_txd) begin
      errors++; $display("FAIL mid_bit3 got %b want %b", txd, m_txd);
    end
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (txd !== 1'b1) begin
      errors++; $display("FAIL mid_txd got %b want 1", txd);
    end
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL mid_level got %0d want 0", fifo_level);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL mid_busy got %b want 0", busy);
    end
    step();
    reset = 1'b0;
    model_clear();
    push_word(9'($urandom), 8'($urandom));
    for (int i = 0; i < 12; i++) begin
      tick();
      checks += 2;
      if (txd !== m_txd) begin
        errors++; $display("FAIL mid_txd%0d got %b want %b", i, txd, m_txd);
      end
      if (cur_adrs !== m_cur) begin
        errors++; $display("FAIL mid_adrs%0d got %0h want %0h", i, cur_adrs, m_cur);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 2) != 0)
          push_word(9'($urandom), 8'($urandom));
        tick();
        checks += 5;
        if (txd !== m_txd) begin
          errors++; $display("FAIL rnd_txd got %b want %b", txd, m_txd);
        end
        if (busy !== m_busy) begin
          errors++; $display("FAIL rnd_busy got %b want %b", busy, m_busy);
        end
        if (cur_adrs !== m_cur) begin
          errors++; $display("FAIL rnd_adrs got %0h want %0h", cur_adrs, m_cur);
        end
        if (fifo_level !== 3'(mq.size())) begin
          errors++; $display("FAIL rnd_level got %0d want %0d", fifo_level, mq.size());
        end
        if (overflow !== m_ovf) begin
          errors++; $display("FAIL rnd_ovf got %b want %b", overflow, m_ovf);
        end
      end
      for (int i = 0; i < 70; i++) tick();
      checks += 3;
      if (busy !== 1'b0 || m_busy) begin
        errors++; $display("FAIL rnd_drain got %b want 0", busy);
      end
      if (fifo_level !== 3'd0) begin
        errors++; $display("FAIL rnd_empty got %0d want 0", fifo_level);
      end
      if (txd !== 1'b1) begin
        errors++; $display("FAIL rnd_idle got %b want 1", txd);
      end
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      m_ovf = 1'b0;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_known_frame();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_txc_reset();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 Parameter DATA_W, default 8: width of one data word.
REQ-002 Parameter ADRS_W, default 9: width of the ramadrs tag carried with each word.
REQ-003 Parameter FIFO_DEPTH, default 4: holding-FIFO entries, power of two >= 2.
REQ-004 clock  input  1  single clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 ramadrs  input  ADRS_W  address counter from the upstream control stage; tag for the accompanying word.
REQ-007 oeenable  input  1  one-clock write strobe; datain and ramadrs are valid in that cycle.
REQ-008 txc  input  1  transmit clock level from control; sampled synchronously, never used as a clock.
REQ-009 datain  input  DATA_W  word read from the data store.
REQ-010 clr_ovf  input  1  synchronous clear of overflow.
REQ-011 txd  output  1  serial line; idle high.
REQ-012 busy  output  1  high whenever the FSM is not IDLE.
REQ-013 fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 overflow  output  1  sticky; a word was dropped.
REQ-015 cur_adrs  output  ADRS_W  tag of the frame in progress, or of the last frame sent.

Function
REQ-016 The block SHALL register txc into txc_q every clock and define tick = txc & ~txc_q.
REQ-017 When oeenable=1 and the FIFO is not full, or is full but a pop occurs in the same cycle, the block SHALL push {ramadrs, datain}.
REQ-018 When oeenable=1, the FIFO is full, and no pop occurs that cycle, the block SHALL drop the word, leave the FIFO unchanged and set overflow on the next edge.
REQ-019 When a push and a pop occur in the same cycle, fifo_level SHALL be unchanged and FIFO order SHALL be preserved.
REQ-020 The FIFO SHALL be first-in first-out, with pointers wrapping modulo FIFO_DEPTH; a pop SHALL never occur when the FIFO is empty.
REQ-021 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, and advance only on tick.
REQ-022 IDLE with tick and FIFO non-empty: pop, load shift register and cur_adrs, txd<=0, go to START; with the FIFO empty, stay in IDLE with txd=1.
REQ-023 START with tick: txd<=data[0], bitcnt<=0, go to DATA.
REQ-024 DATA with tick: if bitcnt<DATA_W-1, txd<=data[bitcnt+1] and bitcnt increments; otherwise txd<=even parity (XOR of all data bits) and go to PARITY.
REQ-025 PARITY with tick: txd<=1, go to STOP.
REQ-026 STOP with tick: if the FIFO is non-empty, pop, txd<=0 and go to START (back-to-back frames); otherwise go to IDLE with txd=1.
REQ-027 Each frame SHALL be 1 start + DATA_W data bits (LSB first) + 1 parity + 1 stop, i.e. DATA_W+3 ticks, with each bit held from one tick to the next.
REQ-028 txd, busy, fifo_level, overflow and cur_adrs SHALL be registered outputs, updated on the edge after the causing event.
REQ-029 If clr_ovf and a new drop occur in the same cycle, overflow SHALL remain set.
REQ-030 oeenable activity SHALL not disturb a frame in progress.

Reset
REQ-031 Reset SHALL force txd=1, busy=0, fifo_level=0, overflow=0, cur_adrs=0, state=IDLE, bitcnt=0, FIFO pointers=0.
REQ-032 Reset SHALL force txc_q=1, so that txc already high at reset release produces no tick.
REQ-033 Reset asserted mid-frame SHALL abort the frame, discard FIFO contents and return txd high within the same clock period, without waiting for a clock edge.

Verification
REQ-034 Push datain=0xA5, ramadrs=0x020, then ticks -> txd = 0,1,0,1,0,0,1,0,1,0,1 over 11 ticks; cur_adrs=0x020; busy falls after the stop-bit tick.
REQ-035 Five oeenable pulses with no ticks and DATA_W=8 -> fifo_level=4 and overflow=1; the first four words transmit in order; clr_ovf -> overflow=0.
REQ-036 Full FIFO with oeenable coinciding with the IDLE tick pop -> word accepted, fifo_level stays 4, overflow stays 0.
REQ-037 Two queued words -> the second start bit follows the first stop bit on the next tick with no idle gap; busy stays high throughout.
REQ-038 txc held high across reset release -> no tick and txd=1 until txc goes low then high again.
REQ-039 Reset pulsed during DATA bit 3 -> txd=1, fifo_level=0, busy=0 immediately; the next push transmits normally.
